// File: rtl/pack_u32_stream.sv
// LEB128 byte-stream encoder for one W-bit value per handshake; define LEB128_SIGNED_EN for SLEB128.
// Latency: first byte the cycle after acceptance. Backpressure: byte held until o_ready; i_ready only when idle or on the last byte.
module pack_u32_stream #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_valid,
  output logic         i_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         o_ready,
  output logic [7:0]   o_data,
  output logic         o_last
);

  localparam int MAXB = (W + 6) / 7;
  localparam int IW   = $clog2(MAXB);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  sh, sh_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic [7:0]    dat_nxt;
  logic          last_nxt;
  logic          more_nxt;

  function automatic logic [W-1:0] shr7(input logic [W-1:0] v);
`ifdef LEB128_SIGNED_EN
    return $signed(v) >>> 7;
`else
    return v >> 7;
`endif
  endfunction

  // The byte at index MAXB-1 always terminates the value, whatever the remaining bits.
  function automatic logic more_of(input logic [W-1:0] v, input logic [IW-1:0] ix);
    logic [W-1:0] s;
    s = shr7(v);
    if (ix == IW'(MAXB - 1)) return 1'b0;
`ifdef LEB128_SIGNED_EN
    return !((s == '0 && !v[6]) || (s == '1 && v[6]));
`else
    return s != '0;
`endif
  endfunction

  assign o_valid = (state == EMIT);
  assign i_ready = (state == IDLE) | (o_valid & o_ready & o_last);

  always_comb begin
    state_nxt = state;
    sh_nxt    = sh;
    idx_nxt   = idx;
    if (i_valid && i_ready) begin
      sh_nxt    = i_data;
      idx_nxt   = '0;
      state_nxt = EMIT;
    end else if (state == EMIT && o_ready) begin
      if (o_last) begin
        sh_nxt    = '0;
        idx_nxt   = '0;
        state_nxt = IDLE;
      end else begin
        sh_nxt  = shr7(sh);
        idx_nxt = idx + IW'(1);
      end
    end
    // Output byte is precomputed from the next shift-register contents so it is registered.
    more_nxt = more_of(sh_nxt, idx_nxt);
    dat_nxt  = 8'h00;
    last_nxt = 1'b0;
    if (state_nxt == EMIT) begin
      dat_nxt  = {more_nxt, sh_nxt[6:0]};
      last_nxt = ~more_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      sh     <= '0;
      idx    <= '0;
      o_data <= 8'h00;
      o_last <= 1'b0;
    end else begin
      state  <= state_nxt;
      sh     <= sh_nxt;
      idx    <= idx_nxt;
      o_data <= dat_nxt;
      o_last <= last_nxt;
    end
  end

endmodule

// File: tb/tb_pack_u32_stream.sv
// Scoreboard bench: accepted values are expanded into expected LEB128 bytes by an arithmetic model.
module tb_pack_u32_stream;

  localparam int W    = 32;
  localparam int MAXB = 5;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         i_valid;
  logic         i_ready;
  logic [W-1:0] i_data;
  logic         o_valid;
  logic         o_ready;
  logic [7:0]   o_data;
  logic         o_last;

  pack_u32_stream #(.W(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_data  (i_data),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_last  (o_last)
  );

  always #5 clk = ~clk;

  int         tests  = 0;
  int         failed = 0;
  int         out_cnt = 0;
  int         rdy_mode = 0;
  int         pi = 0;
  logic [8:0] exp_q[$];
  logic       pat [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic note_fail(input string name);
    tests++;
    failed++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Reference model: {last, byte} entries derived from LEB128 rules with integer arithmetic.
  task automatic model(input logic [31:0] v);
`ifdef LEB128_SIGNED_EN
    longint s;
    int     c;
    logic   more;
    s = longint'($signed(v));
    for (int n = 0; n < MAXB; n++) begin
      c    = int'(s & 127);
      s    = (s - c) / 128;
      more = !((s == 0 && c < 64) || (s == -1 && c >= 64)) && (n < MAXB - 1);
      exp_q.push_back({~more, more, 7'(c)});
      if (!more) break;
    end
`else
    longint unsigned x;
    int              c;
    logic            more;
    x = longint'(v);
    for (int n = 0; n < MAXB; n++) begin
      c    = int'(x % 128);
      x    = x / 128;
      more = (x != 0) && (n < MAXB - 1);
      exp_q.push_back({~more, more, 7'(c)});
      if (!more) break;
    end
`endif
  endtask

  // Input monitor: the handshake completes at the following rising edge.
  always @(negedge clk) begin
    if (reset_n && i_valid && i_ready) model(i_data);
  end

  // Output monitor.
  logic       prev_acc = 1'b0;
  logic       prev_stall = 1'b0;
  logic [8:0] prev_byte = '0;
  logic [8:0] e;
  always @(negedge clk) begin
    if (reset_n) begin
      if (prev_acc) chk("latency_no_bubble", 64'(o_valid), 64'(1));
      if (prev_stall) begin
        chk("hold_valid", 64'(o_valid), 64'(1));
        chk("hold_byte", 64'({o_last, o_data}), 64'(prev_byte));
      end
      chk("i_ready_rule", 64'(i_ready), 64'(!o_valid || (o_ready && o_last)));
      if (o_valid && o_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          failed++;
          $display("FAIL unexpected_byte: got %0h expected none at %0t", o_data, $time);
        end else begin
          e = exp_q.pop_front();
          chk("byte", 64'({o_last, o_data}), 64'(e));
        end
        out_cnt++;
      end
      prev_acc   = i_valid && i_ready;
      prev_stall = o_valid && !o_ready;
      prev_byte  = {o_last, o_data};
    end else begin
      prev_acc   = 1'b0;
      prev_stall = 1'b0;
    end
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: o_ready = 1'b1;
      1: o_ready = 1'($urandom_range(0, 1));
      default: begin
        o_ready = pat[pi];
        pi = (pi + 1) % 8;
      end
    endcase
  end

  task automatic send(input logic [31:0] v);
    int   n;
    logic acc;
    i_valid = 1'b1;
    i_data  = v;
    n = 0;
    do begin
      @(negedge clk);
      acc = i_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 500);
    if (!acc) note_fail("accept_timeout");
  endtask

  task automatic idle(input int cycles);
    i_valid = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_empty", 64'(exp_q.size()), 64'(0));
  endtask

  logic [31:0] rv;
  int          target;
  int          n;

  initial begin
    reset_n = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    o_ready = 1'b0;
    #1;
    chk("reset_o_valid", 64'(o_valid), 64'(0));
    chk("reset_o_data", 64'(o_data), 64'(0));
    chk("reset_o_last", 64'(o_last), 64'(0));
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    chk("reset_i_ready", 64'(i_ready), 64'(1));

    // Directed cases.
    send(32'h0);
    idle(3);
    send(32'd624485);
    idle(6);
    send(32'hFFFF_FFFF);
    send(32'h0000_007F);
    idle(8);
    rdy_mode = 2;
    pi = 0;
    send(32'h80);
    idle(1);
    drain();
    rdy_mode = 0;
`ifdef LEB128_SIGNED_EN
    send(32'hFFFE_1DC0);
    send(32'hFFFF_FFFF);
    send(32'd64);
    idle(2);
    drain();
`endif

    // Reset after the second byte of a multi-byte value.
    send(32'h1234_5678);
    i_valid = 1'b0;
    target = out_cnt + 2;
    n = 0;
    while (out_cnt < target && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (out_cnt < target) note_fail("mid_reset_wait");
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_reset_o_valid", 64'(o_valid), 64'(0));
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("post_reset_no_residual", 64'(o_valid), 64'(0));
      chk("post_reset_i_ready", 64'(i_ready), 64'(1));
    end
    @(posedge clk);
    #1;

    // Randomized traffic with random backpressure and gaps.
    rdy_mode = 1;
    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 4))
        0: rv = $urandom_range(0, 127);
        1: rv = 32'(1) << $urandom_range(0, 31);
        2: rv = 32'hFFFF_FFFF - $urandom_range(0, 3);
        default: rv = $urandom;
      endcase
      send(rv);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(1);
    rdy_mode = 0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pack_u32_stream.md
Name: pack_u32_stream

Overview:
- Sequential LEB128 encoder for 32-bit unsigned values. It is the transmit-side counterpart of the combinational LEB128 unpacker.
- Accepts one W-bit value per input handshake and emits its LEB128 bytes one per cycle on a byte stream with valid/ready.
- Sits between the value producer and the byte-serial packer/output FIFO.

Parameters:
- W, 32, input value width; supported range 8..64. MAXB = ceil(W/7) is a derived localparam (5 for W=32).

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- i_valid  input  1  input value valid
- i_ready  output  1  encoder can accept a value this cycle
- i_data  input  W  value to encode
- o_valid  output  1  output byte valid
- o_ready  input  1  downstream accepts byte
- o_data  output  8  LEB128 byte: bit7 = continuation, bits6:0 = chunk
- o_last  output  1  current byte is the final byte of the value (bit7 == 0)

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low; assertion clears all state immediately, with no clock required.
- Reset values: state = IDLE, o_valid = 0, o_data = 0x00, o_last = 0, i_ready = 1 (after deassertion), shift register = 0, byte index = 0.
- State IDLE:
  - i_ready = 1, o_valid = 0.
  - On i_valid & i_ready, load the shift register with i_data, clear the byte index and go to EMIT.
  - Latency: the first byte is valid on the cycle after acceptance.
- State EMIT:
  - o_valid = 1.
  - o_data[6:0] = shift register [6:0].
  - o_data[7] = more, where more = (shift register >> 7) != 0. When byte index == MAXB-1, more is forced to 0.
  - o_last = ~more.
  - o_data and o_last are registered and stay stable while o_valid & ~o_ready.
- On o_valid & o_ready with more = 1: the shift register shifts right by 7 (logical, zero fill), the byte index increments and the block stays in EMIT.
- On o_valid & o_ready with more = 0 (last byte):
  - i_ready = 1 combinationally in this cycle (back-to-back support).
  - If i_valid is also high, load the new value and stay in EMIT; the first byte of the new value appears next cycle with no bubble.
  - Otherwise go to IDLE.
- i_ready = (state == IDLE) | (o_valid & o_ready & o_last). i_ready never depends on i_valid.
- Byte count per value: 1..MAXB. A value of 0 produces the single byte 0x00. For W=32 the 5th byte carries only bits 31:28, so its upper chunk bits are 0.
- Backpressure: o_ready may be held low indefinitely; no byte is dropped or duplicated. Once raised, o_valid stays high until the byte is accepted.
- Reset mid-value: any remaining bytes are discarded and the block returns to IDLE immediately. No partial byte is emitted after reset deasserts.
- If i_valid is presented while the block is busy on a non-last byte, it is ignored (i_ready = 0). The producer must hold i_valid.

Optional Feature:
- Macro: LEB128_SIGNED_EN.
- Defined (SLEB128 mode):
  - i_data is interpreted as two's complement.
  - The shift is arithmetic (sign fill).
  - Stop condition: more = 0 when (shifted == 0 and chunk bit6 == 0) or (shifted == all-ones and chunk bit6 == 1). Byte MAXB-1 is still forced last.
  - The final byte for W=32 carries sign-extended bits.
- Undefined: unsigned ULEB128 behaviour exactly as specified above, with no signed logic present.

Test Plan:
- reset_n low then high; i_valid = 1, i_data = 0 -> one byte 0x00 with o_last = 1 on the cycle after acceptance; i_ready back to 1.
- i_data = 624485 (0x00098765), o_ready tied 1 -> bytes 0xE5, 0x8E, 0x26 on consecutive cycles; o_last only on 0x26.
- i_data = 0xFFFFFFFF, then 0x0000007F offered back-to-back -> 0xFF, 0xFF, 0xFF, 0xFF, 0x0F, then 0x7F on the next cycle (no bubble); i_ready high only on the IDLE and last-byte cycles.
- i_data = 0x80 with o_ready toggling 0,0,1,0,1 -> 0x80 held stable until accepted, then 0x01 with o_last = 1; no duplicate bytes.
- i_data = 0x12345678; assert reset_n low after the 2nd byte is accepted -> o_valid = 0 asynchronously; after release the block is IDLE, i_ready = 1, and no residual bytes appear.
- With LEB128_SIGNED_EN defined: i_data = -123456 (0xFFFE1DC0) -> 0xC0, 0xBB, 0x78; i_data = -1 -> single byte 0x7F; i_data = 64 -> 0xC0, 0x00.
